bram_dp_init: RTL and testbench
===============================

BRAM_DP_INIT -- requirements
Module: bram_dp_init

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 1024, number of words; power of two, at least 4.
REQ-003 SHALL have parameter ADDR_W, default 10, address width; SHALL equal log2(DEPTH).
REQ-004 SHALL have parameter RDW_MODE, default 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data).
REQ-005 SHALL have parameter OUT_REG, default 0, extra output register stage: 0 = off, 1 = on.
REQ-006 SHALL have parameter CLEAR_ON_RESET, default 1: 1 = zero all words after reset, 0 = contents untouched.
REQ-007 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-009 SHALL have ports en_a/en_b, input, 1 bit each: per-port access enable.
REQ-010 SHALL have ports we_a/we_b, input, 1 bit each: write enable, qualified by en_x.
REQ-011 SHALL have ports addr_a/addr_b, input, ADDR_W each: word address.
REQ-012 SHALL have ports din_a/din_b, input, WIDTH each: write data.
REQ-013 SHALL have ports dout_a/dout_b, output, WIDTH each: read data.
REQ-014 SHALL have ports valid_a/valid_b, output, 1 bit each: dout_x updated this cycle.
REQ-015 SHALL have port ready, output, 1 bit: high when clear is done and accesses are accepted.

Function
REQ-016 SHALL implement a clear FSM with states CLEAR and READY. Reset enters CLEAR if CLEAR_ON_RESET=1, otherwise READY.
REQ-017 In CLEAR, SHALL write zero to word clr_cnt each cycle, with clr_cnt counting 0..DEPTH-1, then go to READY; clear time is DEPTH cycles, and ready asserts on the cycle after the last clear write.
REQ-018 While ready=0, SHALL ignore en_x, we_x, addr_x and din_x, with no memory change and valid_x=0.
REQ-019 A read (ready & en_x & !we_x) SHALL present data on dout_x with valid_x=1 exactly 1+OUT_REG cycles after the request cycle.
REQ-020 A write (ready & en_x & we_x) SHALL update memory at the clock edge and SHALL also drive dout_x/valid_x at the same latency as a read, with old data (RDW_MODE=0) or din_x (RDW_MODE=1).
REQ-021 dout_x SHALL hold its last value when no access result is due, and valid_x SHALL be 0 in those cycles.
REQ-022 Both ports writing the same address in one cycle: port A data SHALL be stored; each port's own read-back SHALL follow REQ-020.
REQ-023 One port writing while the other reads the same address SHALL return old data to the reader, regardless of RDW_MODE.
REQ-024 Addresses SHALL be used modulo DEPTH, with no out-of-range state.

Reset
REQ-025 When rst_n=0 at a clock edge: dout_a=dout_b=0, valid_a=valid_b=0, ready=0, clr_cnt=0, and the output pipeline SHALL be flushed.
REQ-026 Reset asserted mid-CLEAR SHALL restart the clear from word 0.
REQ-027 Reset asserted mid-read SHALL discard the pending result, with no valid pulse after reset.
REQ-028 With CLEAR_ON_RESET=0, ready SHALL assert on the first edge with rst_n=1.

Structure
REQ-029 A shared package SHALL hold the RDW_MODE encodings (RDW_READ_FIRST=0, RDW_WRITE_FIRST=1) and the FSM state type {CLEAR, READY}.
REQ-030 The per-port read path (RDW mux, optional output register, valid pipeline) SHALL be one sub-module, bram_port_rd, instantiated twice.
REQ-031 Storage SHALL be a single inferred array.
REQ-032 The clear write SHALL share port A's write path, so the design infers true dual-port BRAM.

Verification
(All scenarios use WIDTH=8, DEPTH=16.)
REQ-033 Release reset with CLEAR_ON_RESET=1 -> ready rises exactly 16 cycles later; reading all 16 addresses returns 0x00.
REQ-034 With OUT_REG=0, A writes 0x5A to addr 3, then B reads addr 3 -> dout_b=0x5A with valid_b one cycle after the read; with OUT_REG=1, the same appears two cycles after.
REQ-035 Addr 7 holds 0x11; A writes 0x22 to addr 7 -> dout_a=0x11 with RDW_MODE=0, or 0x22 with RDW_MODE=1.
REQ-036 Same cycle: A writes 0xAA and B writes 0xBB, both to addr 9 -> a later read of addr 9 returns 0xAA.
REQ-037 Same cycle: A writes 0x33 to addr 5 (old value 0x44) while B reads addr 5 -> dout_b=0x44.
REQ-038 Assert rst_n=0 at clear count 8, then release -> clear restarts and ready rises 16 cycles after release; accesses issued while ready=0 produce no valid pulse and no write.

Source files
------------

// File: rtl/bram_dp_init_pkg.sv
// bram_dp_init_pkg: shared encodings for the init-cleared dual-port RAM
package bram_dp_init_pkg;
  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;
endpackage

// File: rtl/bram_dp_init_port_rd.sv
// bram_port_rd: per-port read-during-write select, optional output stage and valid pipeline
module bram_port_rd
  import bram_dp_init_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc,
  input  logic             we,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] mem_rd,
  output logic [WIDTH-1:0] dout,
  output logic             valid
);
  logic             v1_q, v1_d, v2_q, v2_d, wf_q, wf_d;
  logic [WIDTH-1:0] din_q, din_d, o_q, o_d, s1;
  // Result pipeline next state; o_q always holds the last delivered word
  always_comb begin
    v1_d  = acc;
    v2_d  = v1_q;
    wf_d  = acc & we & (RDW_MODE == RDW_WRITE_FIRST);
    din_d = acc ? din : din_q;
    s1    = wf_q ? din_q : mem_rd;
    o_d   = v1_q ? s1 : o_q;
  end
  // Pipeline registers, flushed by reset so no stale result survives it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      wf_q  <= 1'b0;
      din_q <= '0;
      o_q   <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      wf_q  <= wf_d;
      din_q <= din_d;
      o_q   <= o_d;
    end
  end
  assign dout  = (OUT_REG != 0) ? o_q : (v1_q ? s1 : o_q);
  assign valid = (OUT_REG != 0) ? v2_q : v1_q;
endmodule

// File: rtl/bram_dp_init.sv
// bram_dp_init: true dual-port RAM with a zeroing pass after reset
module bram_dp_init
  import bram_dp_init_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int DEPTH          = 1024,
  parameter int ADDR_W         = 10,
  parameter int RDW_MODE       = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_a,
  input  logic              en_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [WIDTH-1:0]  din_a,
  input  logic [WIDTH-1:0]  din_b,
  output logic [WIDTH-1:0]  dout_a,
  output logic [WIDTH-1:0]  dout_b,
  output logic              valid_a,
  output logic              valid_b,
  output logic              ready
);
  logic [WIDTH-1:0]  mem [DEPTH];
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d, wa_addr;
  logic              ready_q, ready_d;
  logic              acc_a, acc_b, clr_we, wa_en, wb_en;
  logic [WIDTH-1:0]  wa_data, rd_a_q, rd_b_q;
  // Clear sequencing; the clear borrows port A's write path so both ports stay plain BRAM ports
  always_comb begin
    clr_we    = rst_n & (state_q == CLEAR);
    state_d   = (clr_we && clr_cnt_q == ADDR_W'(DEPTH - 1)) ? READY : state_q;
    clr_cnt_d = clr_we ? clr_cnt_q + 1'b1 : '0;
    ready_d   = state_d == READY;
    acc_a     = rst_n & ready_q & en_a;
    acc_b     = rst_n & ready_q & en_b;
    wa_en     = clr_we | (acc_a & we_a);
    wa_addr   = clr_we ? clr_cnt_q : addr_a;
    wa_data   = clr_we ? '0 : din_a;
    wb_en     = acc_b & we_b & ~(wa_en & (wa_addr == addr_b));
  end
  // Control state; reset either starts the zeroing pass or goes straight to ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
    end
  end
  // Storage with registered read-first reads; port B yields to port A on a same-word write
  always_ff @(posedge clk) begin
    if (wb_en) mem[addr_b] <= din_b;
    if (wa_en) mem[wa_addr] <= wa_data;
    if (acc_a) rd_a_q <= mem[addr_a];
    if (acc_b) rd_b_q <= mem[addr_b];
  end
  bram_port_rd #(.WIDTH(WIDTH), .RDW_MODE(RDW_MODE), .OUT_REG(OUT_REG)) u_rd_a (
    .clk(clk), .rst_n(rst_n), .acc(acc_a), .we(we_a), .din(din_a),
    .mem_rd(rd_a_q), .dout(dout_a), .valid(valid_a)
  );
  bram_port_rd #(.WIDTH(WIDTH), .RDW_MODE(RDW_MODE), .OUT_REG(OUT_REG)) u_rd_b (
    .clk(clk), .rst_n(rst_n), .acc(acc_b), .we(we_b), .din(din_b),
    .mem_rd(rd_b_q), .dout(dout_b), .valid(valid_b)
  );
  assign ready = ready_q;
endmodule

// File: tb/tb_bram_dp_init.sv
// tb_bram_dp_init: two configurations (read-first/no out reg, write-first/out reg) against a scheduled-result model
module tb_bram_dp_init;
  localparam int W = 8, D = 16, AW = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [W-1:0] din_a = '0, din_b = '0;
  logic [1:0][1:0][W-1:0] dout;
  logic [1:0][1:0] valid;
  logic [1:0] rdy;
  int tests = 0, failed = 0;
  logic [W-1:0] mem_m [D];
  logic slot_v [2][2][4];
  logic [W-1:0] slot_d [2][2][4];
  logic [W-1:0] last_m [2][2];
  logic ev [2][2];
  logic [W-1:0] ed [2][2];
  logic rdy_m = 1'b0;
  int k = 0, t = 0;

  always #5 clk = ~clk;

  bram_dp_init #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .en_a(en_a), .en_b(en_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .din_a(din_a), .din_b(din_b),
    .dout_a(dout[0][0]), .dout_b(dout[0][1]), .valid_a(valid[0][0]), .valid_b(valid[0][1]), .ready(rdy[0])
  );
  bram_dp_init #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en_a(en_a), .en_b(en_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .din_a(din_a), .din_b(din_b),
    .dout_a(dout[1][0]), .dout_b(dout[1][1]), .valid_a(valid[1][0]), .valid_b(valid[1][1]), .ready(rdy[1])
  );

  // One clock: drive inputs, apply the rules to the model, sample outputs 1 time unit after the edge.
  // Config d has read-during-write mode d and result latency 1+d after the request cycle.
  task automatic step(input logic r, input logic ea, input logic wa, input logic [AW-1:0] aa, input logic [W-1:0] da,
                      input logic eb, input logic wb, input logic [AW-1:0] ab, input logic [W-1:0] db);
    logic e [2];
    logic w [2];
    logic [AW-1:0] ad [2];
    logic [W-1:0] dd [2];
    @(negedge clk);
    rst_n = r; en_a = ea; we_a = wa; addr_a = aa; din_a = da;
    en_b = eb; we_b = wb; addr_b = ab; din_b = db;
    e[0] = ea; w[0] = wa; ad[0] = aa; dd[0] = da;
    e[1] = eb; w[1] = wb; ad[1] = ab; dd[1] = db;
    @(posedge clk);
    t++;
    if (!r) begin
      k = 0;
      rdy_m = 1'b0;
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) begin
          last_m[d][p] = '0;
          for (int s = 0; s < 4; s++) slot_v[d][p][s] = 1'b0;
        end
    end else if (rdy_m) begin
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++)
          if (e[p]) begin
            slot_v[d][p][(t + d) % 4] = 1'b1;
            slot_d[d][p][(t + d) % 4] = (w[p] && d == 1) ? dd[p] : mem_m[ad[p]];
          end
      if (e[1] && w[1]) mem_m[ad[1]] = dd[1];
      if (e[0] && w[0]) mem_m[ad[0]] = dd[0];
    end else begin
      k++;
      if (k == D) begin
        rdy_m = 1'b1;
        for (int i = 0; i < D; i++) mem_m[i] = '0;
      end
    end
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        ev[d][p] = slot_v[d][p][t % 4];
        ed[d][p] = ev[d][p] ? slot_d[d][p][t % 4] : last_m[d][p];
        last_m[d][p] = ed[d][p];
        slot_v[d][p][t % 4] = 1'b0;
      end
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    repeat (2) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        tests++;
        if (valid[d][p] !== 1'b0 || dout[d][p] !== 8'h00) begin
          failed++;
          $display("FAIL reset_out cfg%0d port%0d: got valid=%b dout=%h, want valid=0 dout=00", d, p, valid[d][p], dout[d][p]);
        end
      end
    tests++;
    if (rdy !== 2'b00) begin
      failed++;
      $display("FAIL reset_ready: got %b, want 00", rdy);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < D; i++) begin
      idle();
      tests++;
      if (rdy !== ((i == D - 1) ? 2'b11 : 2'b00)) begin
        failed++;
        $display("FAIL clear_ready cycle %0d: got %b, want %b", i + 1, rdy, (i == D - 1) ? 2'b11 : 2'b00);
      end
    end
    for (int i = 0; i < D + 2; i++) begin
      if (i < D) step(1'b1, 1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, AW'(D - 1 - i), '0);
      else idle();
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) begin
          tests++;
          if (valid[d][p] !== ev[d][p] || dout[d][p] !== ed[d][p] || (valid[d][p] === 1'b1 && dout[d][p] !== 8'h00)) begin
            failed++;
            $display("FAIL clear_read cfg%0d port%0d step %0d: got valid=%b dout=%h, want valid=%b dout=%h",
                     d, p, i, valid[d][p], dout[d][p], ev[d][p], ed[d][p]);
          end
        end
    end
  endtask

  task automatic test_write_read();
    step(1'b1, 1'b1, 1'b1, 4'd3, 8'h5A, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'd3, '0);
    tests++;
    if (valid[0][1] !== 1'b1 || dout[0][1] !== 8'h5A || valid[1][1] !== 1'b0) begin
      failed++;
      $display("FAIL wr_rd_lat1: got cfg0 valid=%b dout=%h cfg1 valid=%b, want 1/5a/0", valid[0][1], dout[0][1], valid[1][1]);
    end
    idle();
    tests++;
    if (valid[1][1] !== 1'b1 || dout[1][1] !== 8'h5A || valid[0][1] !== 1'b0 || dout[0][1] !== 8'h5A) begin
      failed++;
      $display("FAIL wr_rd_lat2: got cfg1 valid=%b dout=%h cfg0 valid=%b dout=%h, want 1/5a/0/5a",
               valid[1][1], dout[1][1], valid[0][1], dout[0][1]);
    end
  endtask

  task automatic test_rdw();
    step(1'b1, 1'b1, 1'b1, 4'd7, 8'h11, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b1, 1'b1, 4'd7, 8'h22, 1'b0, 1'b0, '0, '0);
    tests++;
    if (valid[0][0] !== 1'b1 || dout[0][0] !== 8'h11) begin
      failed++;
      $display("FAIL rdw_read_first: got valid=%b dout=%h, want 1/11", valid[0][0], dout[0][0]);
    end
    idle();
    tests++;
    if (valid[1][0] !== 1'b1 || dout[1][0] !== 8'h22) begin
      failed++;
      $display("FAIL rdw_write_first: got valid=%b dout=%h, want 1/22", valid[1][0], dout[1][0]);
    end
  endtask

  task automatic test_collision();
    step(1'b1, 1'b1, 1'b1, 4'd9, 8'hAA, 1'b1, 1'b1, 4'd9, 8'hBB);
    tests++;
    if (valid[0] !== 2'b11 || dout[0][0] !== 8'h00 || dout[0][1] !== 8'h00) begin
      failed++;
      $display("FAIL coll_readback_rf: got valid=%b a=%h b=%h, want 11/00/00", valid[0], dout[0][0], dout[0][1]);
    end
    step(1'b1, 1'b1, 1'b0, 4'd9, '0, 1'b0, 1'b0, '0, '0);
    tests++;
    if (valid[0][0] !== 1'b1 || dout[0][0] !== 8'hAA) begin
      failed++;
      $display("FAIL coll_store_cfg0: got valid=%b dout=%h, want 1/aa", valid[0][0], dout[0][0]);
    end
    tests++;
    if (valid[1] !== 2'b11 || dout[1][0] !== 8'hAA || dout[1][1] !== 8'hBB) begin
      failed++;
      $display("FAIL coll_readback_wf: got valid=%b a=%h b=%h, want 11/aa/bb", valid[1], dout[1][0], dout[1][1]);
    end
    idle();
    tests++;
    if (valid[1][0] !== 1'b1 || dout[1][0] !== 8'hAA) begin
      failed++;
      $display("FAIL coll_store_cfg1: got valid=%b dout=%h, want 1/aa", valid[1][0], dout[1][0]);
    end
  endtask

  task automatic test_cross_port();
    step(1'b1, 1'b1, 1'b1, 4'd5, 8'h44, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b1, 1'b1, 4'd5, 8'h33, 1'b1, 1'b0, 4'd5, '0);
    tests++;
    if (valid[0][1] !== 1'b1 || dout[0][1] !== 8'h44 || dout[0][0] !== 8'h44) begin
      failed++;
      $display("FAIL cross_cfg0: got valid_b=%b b=%h a=%h, want 1/44/44", valid[0][1], dout[0][1], dout[0][0]);
    end
    idle();
    tests++;
    if (valid[1][1] !== 1'b1 || dout[1][1] !== 8'h44 || dout[1][0] !== 8'h33) begin
      failed++;
      $display("FAIL cross_cfg1: got valid_b=%b b=%h a=%h, want 1/44/33", valid[1][1], dout[1][1], dout[1][0]);
    end
  endtask

  task automatic test_reset_mid_read();
    step(1'b1, 1'b1, 1'b0, 4'd3, '0, 1'b1, 1'b0, 4'd5, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (valid !== 4'b0000 || rdy !== 2'b00) begin
        failed++;
        $display("FAIL reset_mid_read step %0d: got valid=%b ready=%b, want 0000/00", i, valid, rdy);
      end
      idle();
    end
  endtask

  task automatic test_reset_mid_clear();
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < D; i++) begin
      if (i == D - 2) step(1'b1, 1'b1, 1'b0, 4'd3, '0, 1'b1, 1'b0, 4'd5, '0);
      else if (i == D - 1) step(1'b1, 1'b1, 1'b1, 4'd2, 8'hEE, 1'b1, 1'b1, 4'd3, 8'hDD);
      else idle();
      tests++;
      if (rdy !== ((i == D - 1) ? 2'b11 : 2'b00) || valid !== 4'b0000) begin
        failed++;
        $display("FAIL restart_clear cycle %0d: got ready=%b valid=%b, want ready=%b valid=0000",
                 i + 1, rdy, valid, (i == D - 1) ? 2'b11 : 2'b00);
      end
    end
    step(1'b1, 1'b1, 1'b0, 4'd2, '0, 1'b1, 1'b0, 4'd3, '0);
    tests++;
    if (valid[0] !== 2'b11 || dout[0][0] !== 8'h00 || dout[0][1] !== 8'h00) begin
      failed++;
      $display("FAIL ignored_write cfg0: got valid=%b a=%h b=%h, want 11/00/00", valid[0], dout[0][0], dout[0][1]);
    end
    idle();
    tests++;
    if (valid[1] !== 2'b11 || dout[1][0] !== 8'h00 || dout[1][1] !== 8'h00) begin
      failed++;
      $display("FAIL ignored_write cfg1: got valid=%b a=%h b=%h, want 11/00/00", valid[1], dout[1][0], dout[1][1]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 150) != 0,
           ($urandom % 4) != 0, $urandom % 2, AW'($urandom), W'($urandom),
           ($urandom % 4) != 0, $urandom % 2, AW'($urandom % 4), W'($urandom));
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) begin
          tests++;
          if (valid[d][p] !== ev[d][p] || dout[d][p] !== ed[d][p]) begin
            failed++;
            $display("FAIL random cfg%0d port%0d step %0d: got valid=%b dout=%h, want valid=%b dout=%h",
                     d, p, i, valid[d][p], dout[d][p], ev[d][p], ed[d][p]);
          end
        end
      tests++;
      if (rdy !== {rdy_m, rdy_m}) begin
        failed++;
        $display("FAIL random_ready step %0d: got %b, want %b%b", i, rdy, rdy_m, rdy_m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_write_read();
    test_rdw();
    test_collision();
    test_cross_port();
    test_reset_mid_read();
    test_reset_mid_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
